needs_engine: RTL

//   Parametrised need-level tracker for the virtual plant. Sits between button/sensor conditioning and the state decoder.

---
 rtl/needs_engine_pkg.sv | 25 ++
 rtl/needs_engine_channel.sv | 80 ++++++++
 rtl/needs_engine.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/needs_engine_pkg.sv
// Shared types, preset codes and level helpers for the need-level tracker.
package needs_engine_pkg;

  localparam logic [3:0] PRESET_ALL_MAX  = 4'd0;
  localparam logic [3:0] PRESET_CH_FIRST = 4'd1;

  typedef enum logic {REST_IDLE, REST_ON} rest_state_e;
  typedef enum logic {MODE_NORMAL, MODE_TEST} mode_e;

  function automatic int unsigned lvl_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Level a test preset forces onto channel ch for preset code sel.
  function automatic int unsigned preset_level(input logic [3:0] sel, input int unsigned ch,
                                               input int unsigned nch, input int unsigned lmax,
                                               input int unsigned llow, input int unsigned linit);
    int unsigned s;
    s = 32'(sel);
    if (sel == PRESET_ALL_MAX) return lmax;
    if (s >= 32'(PRESET_CH_FIRST) && s <= nch) return (s == ch + 32'd1) ? llow : linit;
    return linit;
  endfunction

endpackage

// File: rtl/needs_engine_channel.sv
// One need channel: saturating level, decay counter and feed edge detect.
module needs_engine_channel
  import needs_engine_pkg::*;
#(
  parameter int unsigned     LVLW     = 3,
  parameter int unsigned     LVL_INIT = 6,
  parameter int unsigned     PERW     = 10,
  parameter logic [PERW-1:0] PER      = 10'd300
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            feed,
  input  logic            boost,
  input  logic            feed_en,
  input  logic            clr,
  input  logic            freeze,
  input  logic            rest_hold,
  input  logic            rest_inc,
  input  logic            load,
  input  logic [LVLW-1:0] load_val,
  output logic [LVLW-1:0] level
);

  localparam int unsigned     SW     = LVLW + 1;
  localparam logic [LVLW-1:0] LMAX   = LVLW'(lvl_max(LVLW));
  localparam logic [LVLW-1:0] LINIT  = LVLW'(LVL_INIT);
  localparam logic [PERW-1:0] PER_M1 = PER - PERW'(1);

  logic [LVLW-1:0] lvl_q, lvl_d;
  logic [PERW-1:0] cnt_q, cnt_d;
  logic            feed_q;
  logic            feed_edge_c;
  logic [SW-1:0]   sum_c;

  // A feed edge wins over a decay wrap on the same clk.
  always_comb begin
    lvl_d       = lvl_q;
    cnt_d       = cnt_q;
    feed_edge_c = feed & ~feed_q;
    sum_c       = {1'b0, lvl_q} + (boost ? SW'(2) : SW'(1));
    if (load) begin
      lvl_d = load_val;
    end else if (!freeze) begin
      if (feed_edge_c && feed_en) begin
        lvl_d = (sum_c > {1'b0, LMAX}) ? LMAX : sum_c[LVLW-1:0];
        cnt_d = '0;
      end else if (rest_hold) begin
        cnt_d = '0;
        if (rest_inc && lvl_q != LMAX) lvl_d = lvl_q + LVLW'(1);
      end else if (tick) begin
        if (cnt_q == PER_M1) begin
          cnt_d = '0;
          if (lvl_q != '0) lvl_d = lvl_q - LVLW'(1);
        end else begin
          cnt_d = cnt_q + PERW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= LINIT;
      cnt_q  <= '0;
      feed_q <= 1'b0;
    end else if (clr) begin
      lvl_q  <= LINIT;
      cnt_q  <= '0;
      feed_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      feed_q <= feed;
    end
  end

  assign level = lvl_q;

endmodule

// File: rtl/needs_engine.sv
// Need-level tracker top: channels, rest/mode FSMs and long-press detection.
// Optional alarm outputs are built when NEEDS_ALARM_EN is defined.
module needs_engine
  import needs_engine_pkg::*;
#(
  parameter int unsigned         NCH        = 5,
  parameter int unsigned         LVLW       = 3,
  parameter int unsigned         LVL_INIT   = 6,
  parameter int unsigned         LVL_LOW    = 4,
  parameter int unsigned         PERW       = 10,
  parameter logic [NCH*PERW-1:0] DECAY_PER  = {10'd300, 10'd420, 10'd300, 10'd420, 10'd180},
  parameter int unsigned         REST_CH    = 2,
  parameter int unsigned         REST_PER   = 60,
  parameter int unsigned         HOLD_TICKS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_1s,
  input  logic [NCH-1:0]      feed,
  input  logic [NCH-1:0]      boost,
  input  logic                rest_req,
  input  logic                rest_block,
  input  logic                reset_btn,
  input  logic                test_btn,
  input  logic [3:0]          test_sel,
  output logic [NCH*LVLW-1:0] level,
  output logic                resting,
  output logic                test_mode
`ifdef NEEDS_ALARM_EN
  ,
  output logic [NCH-1:0]      alarm
`endif
);

  localparam int unsigned     RW   = (REST_PER > 1) ? $clog2(REST_PER) : 1;
  localparam int unsigned     HW   = $clog2(HOLD_TICKS + 1);
  localparam logic [LVLW-1:0] LMAX = LVLW'(lvl_max(LVLW));

  rest_state_e     rest_q;
  mode_e           mode_q;
  logic [RW-1:0]   rcnt_q;
  logic            rest_req_q;
  logic            test_btn_q;
  logic [HW-1:0]   hold_q [2];

  logic [1:0]      btn_c;
  logic [1:0]      fire_c;
  logic            soft_rst_c;
  logic            test_fire_c;
  logic            preset_c;
  logic            rest_edge_c;
  logic            rest_exit_c;
  logic            rest_inc_c;
  logic [LVLW-1:0] rest_lvl_c;

  assign rest_lvl_c = level[REST_CH*LVLW +: LVLW];

  always_comb begin
    btn_c       = {test_btn, reset_btn};
    for (int b = 0; b < 2; b++)
      fire_c[b] = tick_1s && btn_c[b] && (hold_q[b] == HW'(HOLD_TICKS - 1));
    soft_rst_c  = fire_c[0];
    test_fire_c = fire_c[1] && (mode_q == MODE_NORMAL);
    preset_c    = (mode_q == MODE_TEST) && test_btn && !test_btn_q;
    rest_edge_c = rest_req && !rest_req_q;
    rest_exit_c = (rest_q == REST_ON) && (rest_block || rest_lvl_c == LMAX);
    rest_inc_c  = (mode_q == MODE_NORMAL) && (rest_q == REST_ON) && !rest_exit_c &&
                  tick_1s && (rcnt_q == RW'(REST_PER - 1));
  end

  // Long-press counters saturate at HOLD_TICKS so each press fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) hold_q[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (!btn_c[b]) hold_q[b] <= '0;
        else if (tick_1s && hold_q[b] != HW'(HOLD_TICKS)) hold_q[b] <= hold_q[b] + HW'(1);
      end
    end
  end

  // Rest and mode FSMs; soft reset restores the power-on state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rest_q     <= REST_IDLE;
      mode_q     <= MODE_NORMAL;
      rcnt_q     <= '0;
      rest_req_q <= 1'b0;
      test_btn_q <= 1'b0;
    end else if (soft_rst_c) begin
      rest_q     <= REST_IDLE;
      mode_q     <= MODE_NORMAL;
      rcnt_q     <= '0;
      rest_req_q <= 1'b0;
      test_btn_q <= 1'b0;
    end else begin
      rest_req_q <= rest_req;
      test_btn_q <= test_btn;
      if (mode_q == MODE_TEST) begin
        if (preset_c) begin
          rest_q <= REST_IDLE;
          rcnt_q <= '0;
        end
      end else begin
        if (test_fire_c) mode_q <= MODE_TEST;
        case (rest_q)
          REST_IDLE: begin
            if (rest_edge_c && !rest_block) begin
              rest_q <= REST_ON;
              rcnt_q <= '0;
            end
          end
          REST_ON: begin
            if (rest_exit_c) begin
              rest_q <= REST_IDLE;
              rcnt_q <= '0;
            end else if (tick_1s) begin
              rcnt_q <= (rcnt_q == RW'(REST_PER - 1)) ? '0 : rcnt_q + RW'(1);
            end
          end
          default: rest_q <= REST_IDLE;
        endcase
      end
    end
  end

  assign resting   = (rest_q == REST_ON);
  assign test_mode = (mode_q == MODE_TEST);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam bit IS_REST = (32'(i) == REST_CH);
    logic [LVLW-1:0] load_val_c;

    assign load_val_c = LVLW'(preset_level(test_sel, 32'(i), NCH, lvl_max(LVLW), LVL_LOW, LVL_INIT));

    needs_engine_channel #(
      .LVLW     (LVLW),
      .LVL_INIT (LVL_INIT),
      .PERW     (PERW),
      .PER      (DECAY_PER[i*PERW +: PERW])
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick_1s),
      .feed      (feed[i]),
      .boost     (boost[i]),
      .feed_en   (!resting),
      .clr       (soft_rst_c),
      .freeze    (test_mode),
      .rest_hold (resting && IS_REST),
      .rest_inc  (rest_inc_c && IS_REST),
      .load      (preset_c),
      .load_val  (load_val_c),
      .level     (level[i*LVLW +: LVLW])
    );
  end

`ifdef NEEDS_ALARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= '0;
    end else if (soft_rst_c || mode_q == MODE_TEST) begin
      alarm <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) alarm[i] <= (level[i*LVLW +: LVLW] < LVLW'(LVL_LOW));
    end
  end
`endif

endmodule
